// File: rtl/jt6295_sh_rst_line_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jt6295_sh_rst_line_pkg
//  Purpose  : Shared defaults for the resettable clock-enabled delay line used
//             by the ADPCM datapath. It aligns per-channel control and
//             recirculates the per-channel accumulator through the 4-slot
//             time-multiplexed pipeline.
//  Contents : c_DEF_WIDTH  - default word width
//             c_DEF_STAGES - default depth (latency in clk_en ticks)
//             c_SLOT_COUNT - channel slots in the multiplexed pipeline
//  Revision : 1.0 - initial release
// ============================================================================
package jt6295_sh_rst_line_pkg;

    localparam int unsigned c_DEF_WIDTH  = 5;
    localparam int unsigned c_DEF_STAGES = 2;
    // A recirculating accumulator needs one stage per channel slot.
    localparam int unsigned c_SLOT_COUNT = 4;

endpackage : jt6295_sh_rst_line_pkg
`default_nettype wire

// File: rtl/jt6295_sh_rst_line.sv
`default_nettype none
// ============================================================================
//  Module   : jt6295_sh_rst_line
//  Purpose  : Clock-enabled, asynchronously resettable delay line. A WIDTH-bit
//             word written at din leaves at drop exactly STAGES clk_en ticks
//             later. Idle cycles (clk_en low) freeze the whole line, so words
//             are never lost or duplicated.
//  Ports    : clk     - clock, rising edge
//             rst     - asynchronous active-high reset, loads RSTVAL everywhere
//             clk_en  - stage-advance enable
//             din     - word entering stage 0
//             drop    - word leaving the last stage (register output only)
//  Revision : 1.0 - initial release
// ============================================================================
module jt6295_sh_rst_line
    import jt6295_sh_rst_line_pkg::*;
#(
    parameter int unsigned      WIDTH  = c_DEF_WIDTH,
    parameter int unsigned      STAGES = c_DEF_STAGES,
    parameter logic [WIDTH-1:0] RSTVAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] drop
);

    // One word per stage; index 0 is the input end.
    logic [WIDTH-1:0] r_stage [STAGES];

    // The asynchronous reset prevents shift-register-LUT mapping. That cost
    // is accepted because the accumulator loop must start from a known value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stage[k] <= RSTVAL;
            end
        end else if (clk_en) begin
            r_stage[0] <= din;
            for (int k = 1; k < STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    // The output comes straight from a register. Feeding drop back into din
    // through combinational logic therefore closes a registered loop.
    assign drop = r_stage[STAGES-1];

endmodule : jt6295_sh_rst_line
`default_nettype wire

// File: tb/tb_jt6295_sh_rst_line.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jt6295_sh_rst_line
//  Purpose  : Self-checking bench for jt6295_sh_rst_line. Four instances cover
//             the reset, latency, hold, feedback and edge-parameter cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jt6295_sh_rst_line;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- A: WIDTH=4 STAGES=4 RSTVAL=0 (async reset test)
    logic       rst_a, en_a;
    logic [3:0] din_a, drop_a;
    jt6295_sh_rst_line #(.WIDTH(4), .STAGES(4), .RSTVAL(4'h0)) u_a (
        .clk(clk), .rst(rst_a), .clk_en(en_a), .din(din_a), .drop(drop_a));

    // ---------------- B: WIDTH=12 STAGES=4 (latency/hold/random/feedback)
    logic        rst_b, en_b, fb_b;
    logic [11:0] drv_b, din_b, drop_b;
    assign din_b = fb_b ? drop_b + 12'd1 : drv_b;
    jt6295_sh_rst_line #(.WIDTH(12), .STAGES(4), .RSTVAL(12'h0)) u_b (
        .clk(clk), .rst(rst_b), .clk_en(en_b), .din(din_b), .drop(drop_b));

    // ---------------- C: WIDTH=1 STAGES=1
    logic       rst_c, en_c;
    logic [0:0] din_c, drop_c;
    jt6295_sh_rst_line #(.WIDTH(1), .STAGES(1), .RSTVAL(1'b0)) u_c (
        .clk(clk), .rst(rst_c), .clk_en(en_c), .din(din_c), .drop(drop_c));

    // ---------------- D: WIDTH=5 STAGES=2 RSTVAL=5'h15
    logic       rst_d, en_d;
    logic [4:0] din_d, drop_d;
    jt6295_sh_rst_line #(.WIDTH(5), .STAGES(2), .RSTVAL(5'h15)) u_d (
        .clk(clk), .rst(rst_d), .clk_en(en_d), .din(din_d), .drop(drop_d));

    // Reference model: a line is a FIFO of the words shifted in, oldest first.
    // It is pre-filled with the reset value, and drop is the oldest entry.
    logic [11:0] mdl_b[$];
    logic [11:0] exp_q_b[$];
    logic [0:0]  mdl_c[$];
    logic [0:0]  exp_q_c[$];

    // Monitors: every clock, the DUT presents drop. Pop the expected value
    // and compare it.
    initial begin : mon_b
        logic [11:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q_b.size() > 0) begin
                e = exp_q_b.pop_front();
                check("b_drop", {20'd0, drop_b}, {20'd0, e});
            end
        end
    end

    initial begin : mon_c
        logic [0:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q_c.size() > 0) begin
                e = exp_q_c.pop_front();
                check("c_drop", {31'd0, drop_c}, {31'd0, e});
            end
        end
    end

    // Drive one cycle of B, update the model, and queue the expected drop
    // for the following edge.
    task automatic step_b(input logic en, input logic fb, input logic [11:0] d);
        logic [11:0] w;
        @(negedge clk);
        en_b  = en;
        fb_b  = fb;
        drv_b = d;
        if (en) begin
            w = fb ? mdl_b[0] + 12'd1 : d;
            mdl_b.push_back(w);
            void'(mdl_b.pop_front());
        end
        exp_q_b.push_back(mdl_b[0]);
    endtask

    task automatic step_c(input logic en, input logic [0:0] d);
        @(negedge clk);
        en_c  = en;
        din_c = d;
        if (en) begin
            mdl_c.push_back(d);
            void'(mdl_c.pop_front());
        end
        exp_q_c.push_back(mdl_c[0]);
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0; din_a = '0;
        rst_b = 1'b1; en_b = 1'b0; fb_b = 1'b0; drv_b = '0;
        rst_c = 1'b1; en_c = 1'b0; din_c = '0;
        rst_d = 1'b1; en_d = 1'b0; din_d = '0;
        #1;
        check("rst_a", {28'd0, drop_a}, 32'h0);
        check("rst_b", {20'd0, drop_b}, 32'h0);
        check("rst_c", {31'd0, drop_c}, 32'h0);
        check("rst_d", {27'd0, drop_d}, 32'h15);
        // Reset must dominate clocking and enables.
        en_d = 1'b1; din_d = 5'h0a;
        @(negedge clk);
        check("rst_d_hold", {27'd0, drop_d}, 32'h15);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
        for (int i = 0; i < 4; i++) mdl_b.push_back(12'h0);
        mdl_c.push_back(1'b0);

        // ---- D: 2-tick latency after reset release
        din_d = 5'h03;
        @(negedge clk);
        check("d_tick1", {27'd0, drop_d}, 32'h15);
        din_d = 5'h1c;
        @(negedge clk);
        check("d_tick2", {27'd0, drop_d}, 32'h03);
        en_d = 1'b0;
        @(negedge clk);
        check("d_hold", {27'd0, drop_d}, 32'h03);

        // ---- A: fill with F, then an async reset mid-cycle
        en_a = 1'b1; din_a = 4'hf;
        repeat (4) @(negedge clk);
        check("a_full", {28'd0, drop_a}, 32'hf);
        #2;
        rst_a = 1'b1;
        #1;
        check("a_async_rst", {28'd0, drop_a}, 32'h0);
        @(negedge clk);
        check("a_rst_held", {28'd0, drop_a}, 32'h0);
        rst_a = 1'b0; din_a = 4'h7;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("a_after_rst", {28'd0, drop_a}, (i == 4) ? 32'h7 : 32'h0);
        end
        en_a = 1'b0;

        fork
            begin : stim_b
                // Latency: din = 1, 2, 3, ... on every cycle
                for (int i = 1; i <= 12; i++) step_b(1'b1, 1'b0, 12'(i));
                // Hold: enable every third cycle while din changes every cycle
                for (int i = 0; i < 30; i++) step_b((i % 3) == 0, 1'b0, 12'($urandom));
                // Random enable and data
                for (int i = 0; i < 300; i++) step_b(1'($urandom), 1'b0, 12'($urandom));
                // Feedback loop: each slot counts independently
                for (int i = 0; i < 16; i++) step_b(1'b1, 1'b1, 12'h0);
                for (int i = 0; i < 40; i++) step_b(1'($urandom), 1'b1, 12'h0);
                step_b(1'b0, 1'b0, 12'h0);
            end
            begin : stim_c
                for (int i = 0; i < 200; i++) step_c(1'($urandom), 1'($urandom));
                step_c(1'b0, 1'b0);
            end
        join

        // Let the monitors drain the queues, with a bound on the wait.
        for (int i = 0; i < 10 && (exp_q_b.size() > 0 || exp_q_c.size() > 0); i++)
            @(negedge clk);
        n_vec++;
        if (exp_q_b.size() != 0 || exp_q_c.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", exp_q_b.size(), exp_q_c.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_jt6295_sh_rst_line
`default_nettype wire
